canonical_code_gen: RTL and testbench

- Parametrised successor to the fixed 10-symbol Huffman length builder.
- Takes a packed vector of per-symbol code lengths, e.g. the length results of the tree-traverse stage, and assigns canonical Huffman codewords.
- Emits one (symbol, codeword, length) beat per coded symbol on a ready/valid stream, with backpressure.
- Adds Kraft-inequality overflow detection and zero-length (unused) symbol skipping, which the earlier block lacked.

---
 rtl/canonical_code_gen_if.sv | 27 ++
 rtl/canonical_code_gen.sv | 101 ++++++++++
 tb/tb_canonical_code_gen.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/canonical_code_gen_if.sv
// canonical_code_gen_if: request/length inputs and codeword stream of the canonical code generator
interface canonical_code_gen_if #(
  parameter int NSYM = 10,
  parameter int MAX_LEN = 9,
  parameter int LEN_W = 4,
  parameter int SYM_W = 4
);
  logic req_coding;
  logic [NSYM*LEN_W-1:0] len_in;
  logic ack_coding;
  logic busy;
  logic data_valid;
  logic out_ready;
  logic [SYM_W-1:0] data_sym;
  logic [MAX_LEN-1:0] data_out;
  logic [LEN_W-1:0] data_len;
  logic done;
  logic err_overflow;
  modport master (
    output req_coding, len_in, out_ready,
    input ack_coding, busy, data_valid, data_sym, data_out, data_len, done, err_overflow
  );
  modport slave (
    input req_coding, len_in, out_ready,
    output ack_coding, busy, data_valid, data_sym, data_out, data_len, done, err_overflow
  );
endinterface

// File: rtl/canonical_code_gen.sv
// canonical_code_gen: assigns canonical Huffman codewords from per-symbol lengths and streams them out
module canonical_code_gen #(
  parameter int NSYM = 10,
  parameter int MAX_LEN = 9,
  parameter int LEN_W = 4,
  parameter int SYM_W = 4
) (
  input logic clk,
  input logic rst_n,
  canonical_code_gen_if.slave bus
);
  localparam int CNT_W = $clog2(NSYM + 1);
  localparam int CODE_W = MAX_LEN + 1;
  localparam int IDX_W = $clog2(((NSYM > MAX_LEN) ? NSYM : MAX_LEN) + 1);
  typedef enum logic [2:0] {IDLE, COUNT, BASE, EMIT, DONE} state_t;
  state_t state, state_next;
  logic [IDX_W-1:0] idx;
  logic [LEN_W-1:0] len_reg [NSYM];
  logic [CNT_W-1:0] bl_count [MAX_LEN+1];
  logic [CODE_W-1:0] next_code [MAX_LEN+1];
  logic [CODE_W-1:0] code, code_new;
  logic [LEN_W-1:0] cur_len;
  logic fire, last, ack_d, done_d, busy_d;
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_next;
  always_comb begin
    cur_len = (idx < IDX_W'(NSYM)) ? len_reg[idx] : '0;
    code_new = (code + CODE_W'(bl_count[idx - 1'b1])) << 1;
    fire = !bus.data_valid || bus.out_ready;
    last = state == COUNT ? idx == IDX_W'(NSYM - 1)
         : state == BASE ? idx == IDX_W'(MAX_LEN)
         : idx == IDX_W'(NSYM);
    state_next = state == IDLE ? (bus.req_coding ? COUNT : IDLE)
               : state == COUNT ? (last ? BASE : COUNT)
               : state == BASE ? (last ? EMIT : BASE)
               : state == EMIT ? ((fire && last) ? DONE : EMIT)
               : IDLE;
  end
  always_comb begin
    ack_d = state == IDLE && bus.req_coding;
    done_d = state_next == DONE;
    busy_d = state_next != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
      code <= '0;
      bus.ack_coding <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.data_valid <= 1'b0;
      bus.data_sym <= '0;
      bus.data_out <= '0;
      bus.data_len <= '0;
      bus.err_overflow <= 1'b0;
      for (int i = 0; i < NSYM; i++) len_reg[i] <= '0;
      for (int i = 0; i <= MAX_LEN; i++) begin
        bl_count[i] <= '0;
        next_code[i] <= '0;
      end
    end else begin
      bus.ack_coding <= ack_d;
      bus.done <= done_d;
      bus.busy <= busy_d;
      case (state)
        IDLE: if (bus.req_coding) begin
          for (int i = 0; i < NSYM; i++) len_reg[i] <= bus.len_in[i*LEN_W +: LEN_W];
          for (int i = 0; i <= MAX_LEN; i++) bl_count[i] <= '0;
          bus.err_overflow <= 1'b0;
          idx <= '0;
        end
        COUNT: begin
          if (cur_len > LEN_W'(MAX_LEN)) begin
            bus.err_overflow <= 1'b1;
            len_reg[idx] <= '0;
          end else if (cur_len != '0) bl_count[cur_len] <= bl_count[cur_len] + 1'b1;
          idx <= last ? IDX_W'(1) : idx + 1'b1;
          if (last) code <= '0;
        end
        BASE: begin
          next_code[idx] <= code_new;
          code <= code_new;
          if (32'(code_new) + 32'(bl_count[idx]) > (32'd1 << idx)) bus.err_overflow <= 1'b1;
          idx <= last ? '0 : idx + 1'b1;
        end
        EMIT: if (fire) begin
          if (last) bus.data_valid <= 1'b0;
          else begin
            bus.data_valid <= cur_len != '0;
            bus.data_sym <= SYM_W'(idx);
            bus.data_len <= cur_len;
            bus.data_out <= next_code[cur_len][MAX_LEN-1:0];
            if (cur_len != '0) next_code[cur_len] <= next_code[cur_len] + 1'b1;
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_canonical_code_gen.sv
// tb_canonical_code_gen: scoreboard bench for the canonical code generator
module tb_canonical_code_gen;
  localparam int NSYM = 10, MAX_LEN = 9, LEN_W = 4, SYM_W = 4;
  localparam int DONE_LAT = 1 + 2*NSYM + MAX_LEN;
  localparam logic [NSYM*LEN_W-1:0] NOM = 40'h5544433332;
  typedef struct packed {
    logic [SYM_W-1:0] sym;
    logic [MAX_LEN-1:0] code;
    logic [LEN_W-1:0] len;
  } beat_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  beat_t q[$];
  canonical_code_gen_if #(.NSYM(NSYM), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .SYM_W(SYM_W)) bus();
  canonical_code_gen #(.NSYM(NSYM), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .SYM_W(SYM_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic push_nominal();
    int codes[NSYM] = '{0, 2, 3, 4, 5, 12, 13, 14, 30, 31};
    int lens[NSYM] = '{2, 3, 3, 3, 3, 4, 4, 4, 5, 5};
    for (int i = 0; i < NSYM; i++) q.push_back('{sym: SYM_W'(i), code: MAX_LEN'(codes[i]), len: LEN_W'(lens[i])});
  endtask
  task automatic push_model(input logic [NSYM*LEN_W-1:0] lv, output int err_lat);
    int len[NSYM];
    int blc[MAX_LEN+1];
    int nc[MAX_LEN+1];
    int code;
    err_lat = -1;
    for (int l = 0; l <= MAX_LEN; l++) blc[l] = 0;
    for (int i = 0; i < NSYM; i++) begin
      len[i] = int'(lv[i*LEN_W +: LEN_W]);
      if (len[i] > MAX_LEN) begin
        len[i] = 0;
        if (err_lat < 0) err_lat = 1 + i;
      end else if (len[i] > 0) blc[len[i]]++;
    end
    code = 0;
    for (int l = 1; l <= MAX_LEN; l++) begin
      code = ((code + blc[l-1]) << 1) & ((1 << (MAX_LEN + 1)) - 1);
      nc[l] = code;
      if (code + blc[l] > (1 << l) && err_lat < 0) err_lat = NSYM + l;
    end
    for (int i = 0; i < NSYM; i++)
      if (len[i] > 0) begin
        q.push_back('{sym: SYM_W'(i), code: MAX_LEN'(nc[len[i]]), len: LEN_W'(len[i])});
        nc[len[i]] = (nc[len[i]] + 1) & ((1 << (MAX_LEN + 1)) - 1);
      end
  endtask
  task automatic run_case(input string tag, input logic [NSYM*LEN_W-1:0] lv, input int exp_err_lat,
                          input int stall_sym, input int stall_n, input bit hold_req);
    int done_lat = -1, err_lat = -1, ack_lat = -1, acks = 0, stalled = 0;
    bit got_done = 0;
    beat_t b;
    @(negedge clk);
    bus.len_in = lv;
    bus.req_coding = 1'b1;
    bus.out_ready = 1'b1;
    for (int lat = 0; lat < 4*DONE_LAT && !got_done; lat++) begin
      @(negedge clk);
      if (!hold_req) bus.req_coding = 1'b0;
      if (lat == 0) check({tag, "/busy"}, bus.busy, 1);
      if (bus.ack_coding) begin
        acks++;
        if (ack_lat < 0) ack_lat = lat;
      end
      if (bus.err_overflow && err_lat < 0) err_lat = lat;
      bus.out_ready = 1'b1;
      if (bus.data_valid && int'(bus.data_sym) == stall_sym && stalled < stall_n) begin
        bus.out_ready = 1'b0;
        stalled++;
        if (q.size() > 0) begin
          check({tag, "/hold_sym"}, bus.data_sym, q[0].sym);
          check({tag, "/hold_code"}, bus.data_out, q[0].code);
          check({tag, "/hold_len"}, bus.data_len, q[0].len);
        end
      end
      if (bus.data_valid && bus.out_ready) begin
        if (q.size() == 0) check({tag, "/extra_beat"}, bus.data_valid, 0);
        else begin
          b = q.pop_front();
          check({tag, "/sym"}, bus.data_sym, b.sym);
          check({tag, "/code"}, bus.data_out, b.code);
          check({tag, "/len"}, bus.data_len, b.len);
        end
      end
      if (bus.done) begin
        got_done = 1;
        done_lat = lat;
      end
    end
    bus.req_coding = 1'b0;
    check({tag, "/done_seen"}, got_done, 1);
    check({tag, "/ack_lat"}, ack_lat, 0);
    check({tag, "/acks"}, acks, 1);
    check({tag, "/done_lat"}, done_lat, DONE_LAT + stall_n);
    check({tag, "/lost_beats"}, q.size(), 0);
    check({tag, "/err_lat"}, err_lat, exp_err_lat);
    @(negedge clk);
    check({tag, "/done_pulse"}, bus.done, 0);
    check({tag, "/idle"}, bus.busy, 0);
    q.delete();
  endtask
  task automatic reset_mid_emit();
    int dones = 0;
    @(negedge clk);
    bus.len_in = NOM;
    bus.req_coding = 1'b1;
    bus.out_ready = 1'b1;
    repeat (25) begin
      @(negedge clk);
      bus.req_coding = 1'b0;
    end
    check("rst/valid_before", bus.data_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst/valid", bus.data_valid, 0);
    check("rst/busy", bus.busy, 0);
    check("rst/ack", bus.ack_coding, 0);
    check("rst/done", bus.done, 0);
    check("rst/err", bus.err_overflow, 0);
    check("rst/sym", bus.data_sym, 0);
    check("rst/code", bus.data_out, 0);
    check("rst/len", bus.data_len, 0);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("rst/no_done", dones, 0);
    check("rst/idle", bus.busy, 0);
  endtask
  initial begin
    int e;
    bus.req_coding = 1'b0;
    bus.len_in = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("init/valid", bus.data_valid, 0);
    check("init/busy", bus.busy, 0);
    check("init/done", bus.done, 0);
    check("init/ack", bus.ack_coding, 0);
    check("init/err", bus.err_overflow, 0);
    rst_n = 1'b1;
    push_nominal();
    run_case("nominal", NOM, -1, -1, 0, 1'b0);
    push_model(40'h0000000101, e);
    run_case("zero_skip", 40'h0000000101, e, -1, 0, 1'b0);
    push_model(40'h3333333333, e);
    check("kraft/model_lat", e, NSYM + 3);
    run_case("kraft", 40'h3333333333, NSYM + 3, -1, 0, 1'b0);
    push_model(40'h55444C3332, e);
    run_case("len12", 40'h55444C3332, 5, -1, 0, 1'b0);
    push_nominal();
    run_case("backpressure", NOM, -1, 5, 3, 1'b0);
    push_nominal();
    run_case("req_held", NOM, -1, -1, 0, 1'b1);
    reset_mid_emit();
    push_nominal();
    run_case("after_reset", NOM, -1, -1, 0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end
endmodule
